// File: rtl/phys_freelist.sv
// Physical-register free list: circular FIFO of free preg indices with wrap-bit pointers.
// Offers up to two pregs per cycle to rename and reclaims up to four per cycle from commit and walk.
module phys_freelist #(
  parameter int PREG_NUM = 64,
  parameter int PREG_W   = 6,
  parameter int ARCH_NUM = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              alloc0_req,
  input  logic              alloc1_req,
  output logic              alloc_ready,
  output logic [PREG_W-1:0] alloc0_prd,
  output logic [PREG_W-1:0] alloc1_prd,
  input  logic              walk_active,
  input  logic              commit0_valid,
  input  logic              commit0_need_to_wb,
  input  logic [PREG_W-1:0] commit0_old_prd,
  input  logic              commit1_valid,
  input  logic              commit1_need_to_wb,
  input  logic [PREG_W-1:0] commit1_old_prd,
  input  logic              rob_walk0_valid,
  input  logic [PREG_W-1:0] rob_walk0_prd,
  input  logic              rob_walk1_valid,
  input  logic [PREG_W-1:0] rob_walk1_prd,
  output logic [PREG_W:0]   free_count,
  output logic              overflow_err
);

  localparam int PTR_W = PREG_W + 1;

  logic [PREG_W-1:0] entry_r [PREG_NUM];
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [PTR_W-1:0]  free_count_r;
  logic              overflow_r;

  logic [PREG_W-1:0] head_idx_s;
  logic [PREG_W-1:0] head_nx_idx_s;
  logic [1:0]        pop_cnt_s;
  logic [3:0]        push_vld_s;
  logic [PREG_W-1:0] push_prd_s [4];
  logic [PREG_W-1:0] push_idx_s [4];
  logic [2:0]        push_cnt_s;
  logic [PTR_W-1:0]  head_nxt_s;
  logic [PTR_W-1:0]  tail_nxt_s;
  logic [PTR_W:0]    occ_nxt_s;
  logic              ovf_s;

  assign free_count   = free_count_r;
  assign overflow_err = overflow_r;

  // Offer path and allocation gate, purely from registered state plus the request bits.
  always_comb begin
    head_idx_s    = head_r[PREG_W-1:0];
    head_nx_idx_s = head_idx_s + PREG_W'(1);
    alloc0_prd    = entry_r[head_idx_s];
    if (alloc0_req) begin
      alloc1_prd = entry_r[head_nx_idx_s];
    end else begin
      alloc1_prd = entry_r[head_idx_s];
    end
    alloc_ready = (free_count_r >= PTR_W'(2)) && !walk_active;
  end

  // Qualify returns (preg 0 is never freed) and pack them densely from the tail.
  always_comb begin
    push_vld_s[0] = commit0_valid && commit0_need_to_wb && (commit0_old_prd != '0);
    push_vld_s[1] = commit1_valid && commit1_need_to_wb && (commit1_old_prd != '0);
    push_vld_s[2] = rob_walk0_valid && (rob_walk0_prd != '0);
    push_vld_s[3] = rob_walk1_valid && (rob_walk1_prd != '0);
    push_prd_s[0] = commit0_old_prd;
    push_prd_s[1] = commit1_old_prd;
    push_prd_s[2] = rob_walk0_prd;
    push_prd_s[3] = rob_walk1_prd;
    push_cnt_s    = 3'd0;
    for (int k = 0; k < 4; k++) begin
      push_idx_s[k] = tail_r[PREG_W-1:0] + PREG_W'(push_cnt_s);
      push_cnt_s    = push_cnt_s + {2'b00, push_vld_s[k]};
    end
  end

  // Pointer advance and overflow detection; occupancy is computed one bit wider so it cannot wrap.
  always_comb begin
    if (alloc_ready) begin
      pop_cnt_s = {1'b0, alloc0_req} + {1'b0, alloc1_req};
    end else begin
      pop_cnt_s = 2'd0;
    end
    head_nxt_s = head_r + PTR_W'(pop_cnt_s);
    tail_nxt_s = tail_r + PTR_W'(push_cnt_s);
    occ_nxt_s  = {1'b0, free_count_r} - (PTR_W+1)'(pop_cnt_s) + (PTR_W+1)'(push_cnt_s);
    ovf_s      = (occ_nxt_s > (PTR_W+1)'(PREG_NUM)) || (PTR_W'(pop_cnt_s) > free_count_r);
  end

  // Head/tail pointers, registered free count and sticky overflow flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_r       <= '0;
      tail_r       <= PTR_W'(PREG_NUM - ARCH_NUM);
      free_count_r <= PTR_W'(PREG_NUM - ARCH_NUM);
      overflow_r   <= 1'b0;
    end else begin
      head_r       <= head_nxt_s;
      tail_r       <= tail_nxt_s;
      free_count_r <= tail_nxt_s - head_nxt_s;
      overflow_r   <= overflow_r | ovf_s;
    end
  end

  // Entry storage; at reset holds every preg not mapped to an architectural register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PREG_NUM; i++) begin
        if (i < PREG_NUM - ARCH_NUM) begin
          entry_r[i] <= PREG_W'(ARCH_NUM + i);
        end else begin
          entry_r[i] <= '0;
        end
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (push_vld_s[k]) begin
          entry_r[push_idx_s[k]] <= push_prd_s[k];
        end
      end
    end
  end

endmodule

// File: doc/phys_freelist.md
Name: phys_freelist

Overview:
- Physical-register free list; the consumer end of the ROB commit and walk ports.
- Hands up to 2 free pregs per cycle to rename for instr0/instr1 prd allocation.
- Reclaims committed old_prd and walked (squashed) prd, up to 4 returns per cycle.
- Circular FIFO of preg indices with wrap-bit head/tail pointers.

Parameters:
PREG_NUM, 64, number of physical registers
PREG_W, 6, preg index width, log2(PREG_NUM)
ARCH_NUM, 32, architectural registers; pregs 0..ARCH_NUM-1 are mapped at reset

Ports:
clock  in  1  clock
reset_n  in  1  asynchronous active-low reset
alloc0_req  in  1  rename consumes one preg for instr0 this cycle
alloc1_req  in  1  rename consumes one preg for instr1 this cycle
alloc_ready  out  1  at least 2 entries free and no walk in progress
alloc0_prd  out  PREG_W  preg offered to instr0
alloc1_prd  out  PREG_W  preg offered to instr1
walk_active  in  1  ROB is walking; allocation blocked
commit0_valid  in  1  ROB commit slot 0
commit0_need_to_wb  in  1  slot 0 writes an lrd
commit0_old_prd  in  PREG_W  preg released by slot 0
commit1_valid  in  1  ROB commit slot 1
commit1_need_to_wb  in  1  slot 1 writes an lrd
commit1_old_prd  in  PREG_W  preg released by slot 1
rob_walk0_valid  in  1  walk slot 0
rob_walk0_prd  in  PREG_W  squashed preg, slot 0
rob_walk1_valid  in  1  walk slot 1
rob_walk1_prd  in  PREG_W  squashed preg, slot 1
free_count  out  PREG_W+1  registered number of free entries
overflow_err  out  1  sticky: push would exceed PREG_NUM or pop exceeded count

Behaviour:
- Storage: PREG_NUM x PREG_W array; head/tail are PREG_W+1 bits, where the MSB is the wrap bit.
- free_count = tail - head, modulo 2^(PREG_W+1).
- Reset (asynchronous, any cycle, including mid-walk):
  - entry i = ARCH_NUM+i for i < PREG_NUM-ARCH_NUM; other entries 0.
  - head=0, tail=PREG_NUM-ARCH_NUM, free_count=32, overflow_err=0, alloc_ready=1.
  - alloc0_prd=32, alloc1_prd=33.
- Offer (combinational from registered state):
  - alloc0_prd = entry[head].
  - alloc1_prd = entry[head+1] if alloc0_req, else entry[head].
- alloc_ready = (free_count >= 2) && !walk_active.
- Pop:
  - Only when alloc_ready.
  - head += alloc0_req + alloc1_req at the clock edge.
  - Requests while !alloc_ready are ignored (no pop) and do not set an error.
- Push candidates, packed in fixed priority order commit0, commit1, walk0, walk1:
  - commitN qualifies when commitN_valid && commitN_need_to_wb && commitN_old_prd != 0.
  - walkN qualifies when rob_walkN_valid && rob_walkN_prd != 0.
  - Preg 0 (x0) is never freed.
- Each qualifying candidate is written at tail+k, where k = number of qualifying earlier candidates; tail += total (0..4).
- Pointer arithmetic wraps modulo PREG_NUM on the index, and the wrap bit toggles.
- Simultaneous push and pop are allowed in one cycle; pushed entries become offerable from the next cycle only.
- Overflow: if free_count - pops + pushes > PREG_NUM:
  - overflow_err is set (sticky until reset);
  - pointers still update;
  - the bench treats this as fatal.
- Latency: a returned preg is offerable 1 cycle after the push edge, provided it is at head.
- No duplicate-detection logic; the ROB guarantees uniqueness.

Test Plan:
- Reset, then alloc0_req=alloc1_req=1 for 1 cycle:
  - before the edge: alloc0_prd=32, alloc1_prd=33;
  - after the edge: alloc0_prd=34, free_count=30.
- alloc1_req only:
  - alloc1_prd = entry[head] = 32;
  - after the edge, head advances by 1 and free_count=31.
- Drain 30 pregs: free_count=2, alloc_ready=1.
  - Pop 1 more: free_count=1, alloc_ready=0.
  - Further requests leave free_count=1 with overflow_err=0.
- Same cycle, with free_count=1:
  - inputs: commit0 (need_to_wb=1, old_prd=5), commit1 (old_prd=0), walk0 prd=40, walk1 prd=41;
  - expect free_count=4 next cycle, with entries appended in order 5, 40, 41.
- walk_active=1 with free_count=10: alloc_ready=0 and requests do not change head.
  - Walk pushes still increment free_count.
- Wrap: cycle 100 pops and 100 pushes so tail crosses index 63 to 0.
  - Offered values follow FIFO order; free_count is correct across the wrap.
- From free_count=64, push 1 → overflow_err=1 and it stays 1 until reset_n is asserted low.
- Assert reset_n low mid-walk → all outputs return to their reset values immediately.
